// File: rtl/key_counter_disp.sv
// Debounced pushbutton step counter with per-digit 7-segment display (hex or BCD digits).
// Optional auto-repeat while the key is held is built when KEYCNT_REPEAT_EN is defined.
module key_counter_disp #(
  parameter int unsigned NUM_DIGITS    = 2,
  parameter int unsigned DEB_CYCLES    = 16,
  parameter int unsigned BCD           = 0,
  parameter int unsigned REPEAT_DELAY  = 64,
  parameter int unsigned REPEAT_PERIOD = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_key,
  input  logic                    i_dir,
  input  logic                    i_clr,
  output logic [4*NUM_DIGITS-1:0] o_count,
  output logic [7*NUM_DIGITS-1:0] o_seg,
  output logic                    o_wrap
);

  localparam int unsigned CNT_W = 4 * NUM_DIGITS;
  localparam int unsigned SEG_W = 7 * NUM_DIGITS;
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [3:0] DIG_MAX = (BCD != 0) ? 4'd9 : 4'd15;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

`ifdef KEYCNT_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} state_t;
  logic [RPT_W-1:0] rpt_cnt_q;
`else
  typedef enum logic {ST_IDLE, ST_HELD} state_t;
`endif

  state_t             state_q;
  logic [1:0]         sync_q;
  logic [DEB_W-1:0]   deb_cnt_q;
  logic               lvl_q;
  logic               lvl_prev_q;
  logic               step_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               wrap_d;
  logic [SEG_W-1:0]   seg_q;
  logic               wrap_q;
  logic               key_s;
  logic               press_c;

  assign key_s   = sync_q[1];
  assign press_c = lvl_prev_q & ~lvl_q;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'h0: seg_enc = 7'b1000000;
      4'h1: seg_enc = 7'b1111001;
      4'h2: seg_enc = 7'b0100100;
      4'h3: seg_enc = 7'b0110000;
      4'h4: seg_enc = 7'b0011001;
      4'h5: seg_enc = 7'b0010010;
      4'h6: seg_enc = 7'b0000010;
      4'h7: seg_enc = 7'b1111000;
      4'h8: seg_enc = 7'b0000000;
      4'h9: seg_enc = 7'b0010000;
      4'hA: seg_enc = 7'b0001000;
      4'hB: seg_enc = 7'b0000011;
      4'hC: seg_enc = 7'b1000110;
      4'hD: seg_enc = 7'b0100001;
      4'hE: seg_enc = 7'b0000110;
      default: seg_enc = 7'b0001110;
    endcase
  endfunction

  // Synchroniser and debouncer; idle level is high (key released)
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q     <= 2'b11;
      deb_cnt_q  <= '0;
      lvl_q      <= 1'b1;
      lvl_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], i_key};
      lvl_prev_q <= lvl_q;
      if (key_s != lvl_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          lvl_q     <= key_s;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  // Step FSM; a debounced release always returns to IDLE before any repeat step
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      step_q    <= 1'b0;
`ifdef KEYCNT_REPEAT_EN
      rpt_cnt_q <= '0;
`endif
    end else begin
      step_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (press_c) begin
            state_q   <= ST_HELD;
            step_q    <= 1'b1;
`ifdef KEYCNT_REPEAT_EN
            rpt_cnt_q <= '0;
`endif
          end
        end
        ST_HELD: begin
          if (lvl_q) begin
            state_q <= ST_IDLE;
`ifdef KEYCNT_REPEAT_EN
          end else if (rpt_cnt_q == DELAY_LAST) begin
            state_q   <= ST_REPEAT;
            step_q    <= 1'b1;
            rpt_cnt_q <= '0;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
`endif
          end
        end
`ifdef KEYCNT_REPEAT_EN
        ST_REPEAT: begin
          if (lvl_q) begin
            state_q <= ST_IDLE;
          end else if (rpt_cnt_q == PERIOD_LAST) begin
            step_q    <= 1'b1;
            rpt_cnt_q <= '0;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Ripple carry/borrow across digits; a carry out of the top digit is a wrap
  always_comb begin
    logic [3:0] dig;
    logic       carry;
    count_d = count_q;
    carry   = 1'b1;
    dig     = 4'd0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      dig = count_q[4*k +: 4];
      if (carry) begin
        if (i_dir) begin
          if (dig == DIG_MAX) begin
            count_d[4*k +: 4] = 4'd0;
          end else begin
            count_d[4*k +: 4] = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            count_d[4*k +: 4] = DIG_MAX;
          end else begin
            count_d[4*k +: 4] = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    wrap_d = carry;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (i_clr) begin
        count_q <= '0;
      end else if (step_q) begin
        count_q <= count_d;
        wrap_q  <= wrap_d;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      seg_q <= {NUM_DIGITS{SEG_ZERO}};
    end else begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        seg_q[7*k +: 7] <= seg_enc(count_q[4*k +: 4]);
      end
    end
  end

  assign o_count = count_q;
  assign o_seg   = seg_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_key_counter_disp.sv
// Directed bench for key_counter_disp: hex and BCD instances share one key/dir/clr/reset stimulus.
module tb_key_counter_disp;

`ifdef KEYCNT_REPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif
  localparam logic [13:0] SEG_00 = {7'b1000000, 7'b1000000};

  logic clk = 1'b0;
  logic rst, key, dir, clr;
  logic [7:0]  cnt_h, cnt_b;
  logic [13:0] seg_h, seg_b;
  logic        wrap_h, wrap_b;
  int checks = 0;
  int failures = 0;
  int wraps_h = 0;
  int wraps_b = 0;

  always #5 clk = ~clk;

  key_counter_disp u_hex (
    .i_clk(clk), .i_rst(rst), .i_key(key), .i_dir(dir), .i_clr(clr),
    .o_count(cnt_h), .o_seg(seg_h), .o_wrap(wrap_h)
  );

  key_counter_disp #(.BCD(1)) u_bcd (
    .i_clk(clk), .i_rst(rst), .i_key(key), .i_dir(dir), .i_clr(clr),
    .o_count(cnt_b), .o_seg(seg_b), .o_wrap(wrap_b)
  );

  always @(negedge clk) begin
    if (wrap_h) wraps_h++;
    if (wrap_b) wraps_b++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic d, input int hold);
    dir = d;
    key = 1'b0;
    tick(hold);
    key = 1'b1;
    tick(40);
  endtask

  initial begin
    rst = 1'b0; key = 1'b1; dir = 1'b1; clr = 1'b0;
    tick(3);
    check_eq("rst_cnt_h", 32'(cnt_h), 32'h00);
    check_eq("rst_seg_h", 32'(seg_h), 32'(SEG_00));
    check_eq("rst_wrap_h", 32'(wrap_h), 32'd0);
    check_eq("rst_seg_b", 32'(seg_b), 32'(SEG_00));
    rst = 1'b1;
    tick(3);

    // First press: step lands on edge 19 after the first low sample
    dir = 1'b1;
    key = 1'b0;
    tick(19);
    check_eq("lat_e18", 32'(cnt_h), 32'h00);
    tick(1);
    check_eq("lat_e19_h", 32'(cnt_h), 32'h01);
    check_eq("lat_e19_b", 32'(cnt_b), 32'h01);
    check_eq("seg_lag", 32'(seg_h), 32'(SEG_00));
    tick(1);
    check_eq("seg_01", 32'(seg_h), 32'({7'b1000000, 7'b1111001}));
    tick(28);
    key = 1'b1;
    tick(40);
    check_eq("one_step", 32'(cnt_h), 32'h01);

    key = 1'b0;
    tick(10);
    key = 1'b1;
    tick(30);
    check_eq("glitch_cnt", 32'(cnt_h), 32'h01);
    check_eq("glitch_wrap", 32'(wraps_h), 32'd0);

    press(1'b0, 30);
    check_eq("down_h", 32'(cnt_h), 32'h00);
    check_eq("down_b", 32'(cnt_b), 32'h00);
    check_eq("down_nowrap", 32'(wraps_h), 32'd0);

    press(1'b0, 30);
    check_eq("uflow_h", 32'(cnt_h), 32'hFF);
    check_eq("uflow_b", 32'(cnt_b), 32'h99);
    check_eq("uflow_wrap_h", 32'(wraps_h), 32'd1);
    check_eq("uflow_wrap_b", 32'(wraps_b), 32'd1);
    check_eq("seg_ff", 32'(seg_h), 32'({7'b0001110, 7'b0001110}));
    check_eq("seg_99", 32'(seg_b), 32'({7'b0010000, 7'b0010000}));

    press(1'b1, 30);
    check_eq("oflow_h", 32'(cnt_h), 32'h00);
    check_eq("oflow_b", 32'(cnt_b), 32'h00);
    check_eq("oflow_wrap_h", 32'(wraps_h), 32'd2);
    check_eq("oflow_wrap_b", 32'(wraps_b), 32'd2);

    for (int i = 0; i < 58; i++) press(1'b1, 25);
    check_eq("run_h", 32'(cnt_h), 32'h3A);
    check_eq("run_b", 32'(cnt_b), 32'h58);
    check_eq("seg_3a", 32'(seg_h), 32'({7'b0110000, 7'b0001000}));
    check_eq("seg_58", 32'(seg_b), 32'({7'b0010010, 7'b0000000}));

    // Clear asserted in the cycle the step pulse is high
    dir = 1'b1;
    key = 1'b0;
    tick(19);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check_eq("clr_h", 32'(cnt_h), 32'h00);
    check_eq("clr_b", 32'(cnt_b), 32'h00);
    tick(10);
    key = 1'b1;
    tick(40);
    check_eq("clr_hold", 32'(cnt_h), 32'h00);
    check_eq("clr_nowrap", 32'(wraps_h), 32'd2);

    // Long hold: key low for edges 0..218
    dir = 1'b1;
    key = 1'b0;
    for (int e = 0; e < 219; e++) begin
      tick(1);
      if (e == 19)  check_eq("hold_e19", 32'(cnt_h), 32'h01);
      if (e == 82)  check_eq("hold_e82", 32'(cnt_h), 32'h01);
      if (e == 83)  check_eq("hold_e83", 32'(cnt_h), RPT ? 32'h02 : 32'h01);
      if (e == 99)  check_eq("hold_e99", 32'(cnt_h), RPT ? 32'h03 : 32'h01);
      if (e == 115) check_eq("hold_e115", 32'(cnt_h), RPT ? 32'h04 : 32'h01);
    end
    key = 1'b1;
    tick(40);
    check_eq("hold_final_h", 32'(cnt_h), RPT ? 32'h0B : 32'h01);
    check_eq("hold_final_b", 32'(cnt_b), RPT ? 32'h11 : 32'h01);

    // Reset in the middle of a hold, key kept low across release
    key = 1'b0;
    tick(120);
    rst = 1'b0;
    tick(2);
    check_eq("mid_rst_cnt", 32'(cnt_h), 32'h00);
    check_eq("mid_rst_seg", 32'(seg_h), 32'(SEG_00));
    check_eq("mid_rst_wrap", 32'(wrap_h), 32'd0);
    check_eq("mid_rst_cnt_b", 32'(cnt_b), 32'h00);
    rst = 1'b1;
    tick(19);
    check_eq("rerel_e18", 32'(cnt_h), 32'h00);
    tick(1);
    check_eq("rerel_e19_h", 32'(cnt_h), 32'h01);
    check_eq("rerel_e19_b", 32'(cnt_b), 32'h01);
    key = 1'b1;
    tick(40);
    check_eq("wraps_total_h", 32'(wraps_h), 32'd2);
    check_eq("wraps_total_b", 32'(wraps_b), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
